pe_row_sequencer: RTL and testbench



---
 rtl/pe_row_sequencer.sv | 135 +++++++++++++
 tb/tb_pe_row_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_sequencer.sv
// Row engine for the PE feed: runs PASSES sparse serial x parallel MAC passes per row, then flushes one lane-wise psum vector.
// Optional build macro PE_PSUM_SAT_EN: saturating accumulation instead of two's-complement wrap.
module pe_row_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PAR_LANES      = 9,
  parameter int PSUM_WIDTH     = 24,
  parameter int IDX_WIDTH      = 4,
  parameter int PASSES         = 3,
  parameter int ROWS_PER_FRAME = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mode,
  input  logic                            en,
  input  logic [DATA_WIDTH-1:0]           serial_in,
  input  logic [PAR_LANES*DATA_WIDTH-1:0] parallel_in,
  input  logic [IDX_WIDTH-1:0]            row_val_num,
  input  logic                            zero_flag,
  output logic [IDX_WIDTH-1:0]            cnt,
  output logic                            row_finish_done_0,
  output logic                            row_cal_done,
  output logic                            row_finish_done_1,
  output logic [PAR_LANES*PSUM_WIDTH-1:0] psum_out,
  output logic                            psum_valid,
  output logic                            busy
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int PC_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int RC_W   = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES - 1);
  localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(ROWS_PER_FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MAC, S_FLUSH} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [IDX_WIDTH-1:0]           r_cnt;
  logic [PC_W-1:0]                r_pass;
  logic [RC_W-1:0]                r_row;
  logic signed [PSUM_WIDTH-1:0]   r_acc     [PAR_LANES];
  logic signed [PSUM_WIDTH-1:0]   w_acc_nxt [PAR_LANES];
  logic [PAR_LANES*PSUM_WIDTH-1:0] r_psum_out;
  logic                           r_psum_valid;
  logic                           w_pass_end;
  logic                           w_row_done;
  logic                           w_frame_done;

  // Operand order follows mode (weight first); the product itself is identical either way.
  function automatic logic signed [PROD_W-1:0] mul_op(
    input logic                         sel,
    input logic signed [DATA_WIDTH-1:0] s,
    input logic signed [DATA_WIDTH-1:0] p
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'(s);
    b = PROD_W'(p);
    return sel ? (a * b) : (b * a);
  endfunction

  function automatic logic signed [PSUM_WIDTH-1:0] acc_add(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic signed [PROD_W-1:0]     p
  );
`ifdef PE_PSUM_SAT_EN
    logic signed [PSUM_WIDTH:0] s;
    s = (PSUM_WIDTH+1)'(a) + (PSUM_WIDTH+1)'(p);
    if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])
      return s[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    return s[PSUM_WIDTH-1:0];
`else
    return a + PSUM_WIDTH'(p);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pass_end   = (r_state == S_MAC) && (zero_flag || (r_cnt == row_val_num));
    w_row_done   = w_pass_end && (r_pass == LAST_PASS);
    w_frame_done = w_row_done && (r_row == LAST_ROW);
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_MAC;
      S_MAC:   if (w_row_done) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = (r_row == LAST_ROW) ? S_IDLE : S_ARM;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < PAR_LANES; k++) begin
      w_acc_nxt[k] = r_acc[k];
      if ((r_state == S_MAC) && !zero_flag)
        w_acc_nxt[k] = acc_add(r_acc[k],
                               mul_op(mode, serial_in, parallel_in[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // psum_out captures the final sums on the row-done cycle so it is presented during FLUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_pass       <= '0;
      r_row        <= '0;
      r_psum_out   <= '0;
      r_psum_valid <= 1'b0;
      for (int k = 0; k < PAR_LANES; k++) r_acc[k] <= '0;
    end else begin
      r_psum_valid <= w_row_done;
      if (r_state == S_MAC) r_cnt <= w_pass_end ? '0 : r_cnt + 1'b1;
      else                  r_cnt <= '0;
      if (w_pass_end) r_pass <= w_row_done ? '0 : r_pass + 1'b1;
      if (r_state == S_FLUSH) r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      for (int k = 0; k < PAR_LANES; k++) begin
        r_acc[k] <= (r_state == S_FLUSH) ? '0 : w_acc_nxt[k];
        if (w_row_done) r_psum_out[k*PSUM_WIDTH +: PSUM_WIDTH] <= w_acc_nxt[k];
      end
    end
  end

  assign cnt               = r_cnt;
  assign row_finish_done_0 = w_pass_end;
  assign row_cal_done      = w_row_done;
  assign row_finish_done_1 = w_frame_done;
  assign psum_out          = r_psum_out;
  assign psum_valid        = r_psum_valid;
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Scoreboard bench for pe_row_sequencer: stimulus queues expected pulses, control values and psum vectors; a negedge monitor compares.
module tb_pe_row_sequencer;
  localparam int DW = 8, PL = 9, PW = 16, IW = 4, NP = 3, RPF = 2;
`ifdef PE_PSUM_SAT_EN
  localparam longint SATV = 32767;
`else
  localparam longint SATV = 4909;
`endif

  logic clk = 1'b0;
  logic reset, mode, en, zero_flag;
  logic [DW-1:0]    serial_in;
  logic [PL*DW-1:0] parallel_in;
  logic [IW-1:0]    row_val_num;
  logic [IW-1:0]    cnt;
  logic             rfd0, rcd, rf1, psum_valid, busy;
  logic [PL*PW-1:0] psum_out;

  pe_row_sequencer #(
    .DATA_WIDTH(DW), .PAR_LANES(PL), .PSUM_WIDTH(PW), .IDX_WIDTH(IW),
    .PASSES(NP), .ROWS_PER_FRAME(RPF)
  ) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .en(en),
    .serial_in(serial_in), .parallel_in(parallel_in),
    .row_val_num(row_val_num), .zero_flag(zero_flag),
    .cnt(cnt), .row_finish_done_0(rfd0), .row_cal_done(rcd),
    .row_finish_done_1(rf1), .psum_out(psum_out), .psum_valid(psum_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int sig; longint val; } ctl_t;
  typedef struct { int c; logic [PL*PW-1:0] d; } ps_t;
  ctl_t q_ctl[$];
  ps_t  q_ps[$];
  int   q_rfd0[$], q_rcd[$], q_rf1[$];
  int   nchk = 0, npass = 0;
  bit   done = 1'b0;

  task automatic check(input string nm, input longint got, input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
  endtask

  // sig codes: 0 cnt, 1 busy, 2 psum_valid, 3 psum_out nonzero, 4 {rf1,rcd,rfd0}
  always @(negedge clk) begin : mon
    ctl_t   e;
    ps_t    p;
    longint g;
    string  nm;
    while (q_ctl.size() > 0 && q_ctl[0].c <= cyc) begin
      e = q_ctl.pop_front();
      case (e.sig)
        0: begin g = longint'(cnt); nm = "cnt"; end
        1: begin g = longint'(busy); nm = "busy"; end
        2: begin g = longint'(psum_valid); nm = "psum_valid"; end
        3: begin g = (psum_out != '0) ? 1 : 0; nm = "psum_out_nonzero"; end
        default: begin g = longint'({rf1, rcd, rfd0}); nm = "pulses"; end
      endcase
      if (e.c == cyc) check(nm, g, e.val);
      else            check({nm, "_missed_cycle"}, longint'(cyc), longint'(e.c));
    end
    if (rfd0) begin
      if (q_rfd0.size() == 0) check("rfd0_unexpected", longint'(cyc), -1);
      else                    check("rfd0_cycle", longint'(cyc), longint'(q_rfd0.pop_front()));
    end
    if (rcd) begin
      if (q_rcd.size() == 0) check("rcd_unexpected", longint'(cyc), -1);
      else                   check("rcd_cycle", longint'(cyc), longint'(q_rcd.pop_front()));
    end
    if (rf1) begin
      if (q_rf1.size() == 0) check("rf1_unexpected", longint'(cyc), -1);
      else                   check("rf1_cycle", longint'(cyc), longint'(q_rf1.pop_front()));
    end
    if (psum_valid) begin
      if (q_ps.size() == 0) check("psum_unexpected", longint'(cyc), -1);
      else begin
        p = q_ps.pop_front();
        check("psum_cycle", longint'(cyc), longint'(p.c));
        for (int k = 0; k < PL; k++)
          check($sformatf("psum_lane%0d", k),
                longint'($signed(psum_out[k*PW +: PW])), longint'($signed(p.d[k*PW +: PW])));
      end
    end
    if (done) begin
      check("pending_expectations",
            longint'(q_ctl.size() + q_ps.size() + q_rfd0.size() + q_rcd.size() + q_rf1.size()), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic exp_ctl(input int c, input int sig, input longint v);
    ctl_t e;
    e.c = c; e.sig = sig; e.val = v;
    q_ctl.push_back(e);
  endtask

  task automatic push_ps(input int c, input int base, input int step);
    ps_t p;
    p.c = c;
    for (int k = 0; k < PL; k++) p.d[k*PW +: PW] = PW'(base + step * k);
    q_ps.push_back(p);
  endtask

  task automatic set_lanes(input int base, input int step);
    for (int k = 0; k < PL; k++) parallel_in[k*DW +: DW] = DW'(base + step * k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    tick();
    reset = 1'b0;
    exp_ctl(cyc, 0, 0);
    exp_ctl(cyc, 1, 0);
    exp_ctl(cyc, 2, 0);
    exp_ctl(cyc, 3, 0);
    exp_ctl(cyc, 4, 0);
  endtask

  task automatic start_row();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    int c0, c1;
    reset = 1'b1; en = 1'b0; mode = 1'b1; zero_flag = 1'b0;
    serial_in = '0; parallel_in = '0; row_val_num = '0;
    tick(); tick();
    do_reset();

    // Basic MAC: 3 passes of 3 elements, serial 1, lane k = k
    mode = 1'b1; zero_flag = 1'b0; row_val_num = 4'd2; serial_in = 8'd1; set_lanes(0, 1);
    tick();
    c0 = cyc;
    exp_ctl(c0 + 1, 1, 1);
    exp_ctl(c0 + 1, 0, 0);
    for (int m = 1; m <= 9; m++) begin
      exp_ctl(c0 + 1 + m, 0, (m - 1) % 3);
      exp_ctl(c0 + 1 + m, 4, (m % 3 != 0) ? 0 : ((m == 9) ? 3 : 1));
    end
    q_rfd0.push_back(c0 + 4); q_rfd0.push_back(c0 + 7); q_rfd0.push_back(c0 + 10);
    q_rcd.push_back(c0 + 10);
    push_ps(c0 + 11, 0, 9);
    start_row();
    run_to(c0 + 11);
    do_reset();

    // Zero passes: no accumulation regardless of operands
    zero_flag = 1'b1; row_val_num = 4'd15; serial_in = 8'd5; set_lanes(7, 0);
    c0 = cyc;
    exp_ctl(c0 + 2, 4, 1);
    exp_ctl(c0 + 3, 0, 0);
    exp_ctl(c0 + 4, 4, 3);
    q_rfd0.push_back(c0 + 2); q_rfd0.push_back(c0 + 3); q_rfd0.push_back(c0 + 4);
    q_rcd.push_back(c0 + 4);
    push_ps(c0 + 5, 0, 0);
    start_row();
    run_to(c0 + 5);
    do_reset();

    // Signed operands, single-element passes, swapped operand role
    mode = 1'b0; zero_flag = 1'b0; row_val_num = 4'd0; serial_in = 8'hFE; set_lanes(3, 0);
    c0 = cyc;
    exp_ctl(c0 + 2, 4, 1);
    exp_ctl(c0 + 4, 4, 3);
    q_rfd0.push_back(c0 + 2); q_rfd0.push_back(c0 + 3); q_rfd0.push_back(c0 + 4);
    q_rcd.push_back(c0 + 4);
    push_ps(c0 + 5, -18, 0);
    start_row();
    run_to(c0 + 5);
    do_reset();

    // Overflow: 45 products of 127*127 in a 16-bit accumulator
    mode = 1'b1; row_val_num = 4'd14; serial_in = 8'd127; set_lanes(127, 0);
    c0 = cyc;
    exp_ctl(c0 + 15, 0, 13);
    exp_ctl(c0 + 16, 0, 14);
    exp_ctl(c0 + 16, 4, 1);
    q_rfd0.push_back(c0 + 16); q_rfd0.push_back(c0 + 31); q_rfd0.push_back(c0 + 46);
    q_rcd.push_back(c0 + 46);
    push_ps(c0 + 47, int'(SATV), 0);
    start_row();
    run_to(c0 + 47);
    do_reset();

    // Frame end: two rows auto-chain from one en; a stray en mid-row is ignored
    row_val_num = 4'd0; serial_in = 8'd1; set_lanes(0, 1);
    c0 = cyc;
    exp_ctl(c0 + 4, 4, 3);
    exp_ctl(c0 + 6, 1, 1);
    exp_ctl(c0 + 9, 4, 7);
    exp_ctl(c0 + 10, 1, 1);
    exp_ctl(c0 + 11, 1, 0);
    exp_ctl(c0 + 11, 0, 0);
    exp_ctl(c0 + 13, 1, 0);
    for (int i = 2; i <= 4; i++) q_rfd0.push_back(c0 + i);
    for (int i = 7; i <= 9; i++) q_rfd0.push_back(c0 + i);
    q_rcd.push_back(c0 + 4); q_rcd.push_back(c0 + 9);
    q_rf1.push_back(c0 + 9);
    push_ps(c0 + 5, 0, 3);
    push_ps(c0 + 10, 0, 3);
    start_row();
    run_to(c0 + 8);
    en = 1'b1;
    tick();
    en = 1'b0;
    run_to(c0 + 13);
    do_reset();

    // Reset mid-pass at cnt=2, then a fresh row must exclude the pre-reset sums
    row_val_num = 4'd5; serial_in = 8'd1; set_lanes(0, 1);
    c0 = cyc;
    exp_ctl(c0 + 4, 0, 2);
    exp_ctl(c0 + 4, 1, 1);
    exp_ctl(c0 + 5, 0, 0);
    exp_ctl(c0 + 5, 1, 0);
    start_row();
    run_to(c0 + 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    row_val_num = 4'd1; serial_in = 8'd2; set_lanes(1, 0);
    c1 = cyc;
    q_rfd0.push_back(c1 + 3); q_rfd0.push_back(c1 + 5); q_rfd0.push_back(c1 + 7);
    q_rcd.push_back(c1 + 7);
    push_ps(c1 + 8, 12, 0);
    start_row();
    run_to(c1 + 8);
    do_reset();

    done = 1'b1;
  end
endmodule
